// File: rtl/keypad_emulator.sv
// Emulates one matrix-keypad key press per request against an external row scanner.
// Optional contact-bounce emulation is enabled by defining KEYPAD_BOUNCE_EN.
module keypad_emulator #(
    parameter logic [31:0] HOLD_CYCLES   = 32'd1000,
    parameter logic [31:0] GAP_CYCLES    = 32'd500,
    parameter logic [31:0] BOUNCE_CYCLES = 32'd16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [3:0] LINE,
    output logic [3:0] COLLUMMN,
    output logic       busy,
    output logic [7:0] press_count,
    output logic [1:0] fsm_state
);

    // Handshake: a request transfers on a rising edge where key_valid and key_ready
    // are both high; key_ready is high only in IDLE, requests seen otherwise are dropped.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] cnt;
    logic [31:0] cnt_next;
    logic [3:0]  code;
    logic [3:0]  code_next;
    logic [7:0]  count;
    logic [7:0]  count_next;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        key_down;
    logic [3:0]  sense;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            code  <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            code  <= code_next;
            count <= count_next;
        end
    end

    // cnt restarts at 0 on every phase entry, so in PRESS it equals k.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        code_next  = code;
        count_next = count;
        case (state)
            IDLE: begin
                if (key_valid) begin
                    state_next = PRESS;
                    cnt_next   = '0;
                    code_next  = key_code;
                end
            end
            PRESS: begin
                if (cnt == HOLD_CYCLES - 32'd1) begin
                    state_next = RELEASE;
                    cnt_next   = '0;
                    count_next = count + 8'd1;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            RELEASE: begin
                if (cnt == GAP_CYCLES - 32'd1) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        row = 2'd0;
        col = 2'd0;
        case (code)
            4'd1:  begin row = 2'd0; col = 2'd0; end
            4'd2:  begin row = 2'd0; col = 2'd1; end
            4'd3:  begin row = 2'd0; col = 2'd2; end
            4'd10: begin row = 2'd0; col = 2'd3; end
            4'd4:  begin row = 2'd1; col = 2'd0; end
            4'd5:  begin row = 2'd1; col = 2'd1; end
            4'd6:  begin row = 2'd1; col = 2'd2; end
            4'd11: begin row = 2'd1; col = 2'd3; end
            4'd7:  begin row = 2'd2; col = 2'd0; end
            4'd8:  begin row = 2'd2; col = 2'd1; end
            4'd9:  begin row = 2'd2; col = 2'd2; end
            4'd12: begin row = 2'd2; col = 2'd3; end
            4'd14: begin row = 2'd3; col = 2'd0; end
            4'd0:  begin row = 2'd3; col = 2'd1; end
            4'd15: begin row = 2'd3; col = 2'd2; end
            4'd13: begin row = 2'd3; col = 2'd3; end
            default: begin row = 2'd0; col = 2'd0; end
        endcase
    end

`ifdef KEYPAD_BOUNCE_EN
    // Bounce window: contact closed for two cycles, open for two, repeating.
    assign key_down = (state == PRESS) && ((cnt >= BOUNCE_CYCLES) || !cnt[1]);
`else
    logic unused_bounce;
    assign unused_bounce = ^BOUNCE_CYCLES;
    assign key_down      = (state == PRESS);
`endif

    // Passive contact: the column follows the driven row with no register in the path.
    always_comb begin
        sense = 4'hF;
        if (key_down && !LINE[row]) begin
            sense[col] = 1'b0;
        end
    end

    assign COLLUMMN    = sense;
    assign key_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign press_count = count;
    assign fsm_state   = state;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: three instances cover the nominal, fast-wrap
// and bounce-window parameter sets.
module tb_keypad_emulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    logic [3:0] exp_q[$];

    logic       a_rst, a_valid, a_ready, a_busy;
    logic [3:0] a_code, a_line, a_coll;
    logic [7:0] a_count;
    logic [1:0] a_state;

    logic       b_rst, b_valid, b_ready, b_busy;
    logic [3:0] b_code, b_line, b_coll;
    logic [7:0] b_count;
    logic [1:0] b_state;

    logic       c_rst, c_valid, c_ready, c_busy;
    logic [3:0] c_code, c_line, c_coll;
    logic [7:0] c_count;
    logic [1:0] c_state;

    logic [3:0] sweep_line [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b0000};
    logic [3:0] sweep_exp  [5] = '{4'hF, 4'b0111, 4'hF, 4'hF, 4'b0111};
`ifdef KEYPAD_BOUNCE_EN
    logic [3:0] bounce_exp [12] = '{4'hE, 4'hE, 4'hF, 4'hF, 4'hE, 4'hE, 4'hF, 4'hF,
                                    4'hE, 4'hE, 4'hE, 4'hE};
`else
    logic [3:0] bounce_exp [12] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE,
                                    4'hE, 4'hE, 4'hE, 4'hE};
`endif

    keypad_emulator #(.HOLD_CYCLES(32'd4), .GAP_CYCLES(32'd3), .BOUNCE_CYCLES(32'd16)) u_a (
        .clk(clk), .rst(a_rst), .key_valid(a_valid), .key_code(a_code), .key_ready(a_ready),
        .LINE(a_line), .COLLUMMN(a_coll), .busy(a_busy), .press_count(a_count),
        .fsm_state(a_state)
    );

    keypad_emulator #(.HOLD_CYCLES(32'd1), .GAP_CYCLES(32'd1), .BOUNCE_CYCLES(32'd16)) u_b (
        .clk(clk), .rst(b_rst), .key_valid(b_valid), .key_code(b_code), .key_ready(b_ready),
        .LINE(b_line), .COLLUMMN(b_coll), .busy(b_busy), .press_count(b_count),
        .fsm_state(b_state)
    );

    keypad_emulator #(.HOLD_CYCLES(32'd12), .GAP_CYCLES(32'd3), .BOUNCE_CYCLES(32'd8)) u_c (
        .clk(clk), .rst(c_rst), .key_valid(c_valid), .key_code(c_code), .key_ready(c_ready),
        .LINE(c_line), .COLLUMMN(c_coll), .busy(c_busy), .press_count(c_count),
        .fsm_state(c_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 50 && !a_ready; i++) step();
        check("a_idle_wait", a_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_coll;

        a_rst = 1'b1; a_valid = 1'b0; a_code = 4'd0; a_line = 4'hF;
        b_rst = 1'b1; b_valid = 1'b0; b_code = 4'd0; b_line = 4'hF;
        c_rst = 1'b1; c_valid = 1'b0; c_code = 4'd0; c_line = 4'hF;
        step();
        step();
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

        check("rst_ready", a_ready, 1);
        check("rst_busy", a_busy, 0);
        check("rst_coll", a_coll, 4'hF);
        check("rst_count", a_count, 0);
        check("rst_state", a_state, 0);
        check("rst_b_count", b_count, 0);

        // key 5 with row 1 driven; code changes after accept must not matter
        a_line = 4'b1101; a_code = 4'd5; a_valid = 1'b1;
        step();
        a_valid = 1'b0; a_code = 4'd9;
        for (int i = 1; i <= 4; i++) exp_q.push_back(4'b1101);
        for (int i = 5; i <= 8; i++) exp_q.push_back(4'hF);
        for (int i = 1; i <= 8; i++) begin
            exp_coll = exp_q.pop_front();
            check("p5_coll", a_coll, exp_coll);
            check("p5_busy", a_busy, (i <= 7) ? 1 : 0);
            check("p5_ready", a_ready, (i == 8) ? 1 : 0);
            check("p5_count", a_count, (i >= 5) ? 1 : 0);
            if (i < 8) step();
        end

        // key B, row sweep within the first PRESS cycle
        a_code = 4'd11; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            a_line = sweep_line[j];
            #1;
            check("sweep_coll", a_coll, sweep_exp[j]);
        end
        wait_idle_a();
        check("sweep_count", a_count, 2);
        a_line = 4'h0;
        #1;
        check("idle_coll_line0", a_coll, 4'hF);

        // key_valid held through busy; code switches from '*' to '#'
        a_line = 4'b0111; a_code = 4'd14; a_valid = 1'b1;
        step();
        for (int i = 1; i <= 8; i++) begin
            if (i == 2) a_code = 4'd15;
            #1;
            check("hold_coll", a_coll, (i <= 4) ? 4'b1110 : 4'hF);
            check("hold_ready", a_ready, (i == 8) ? 1 : 0);
            if (i < 8) step();
        end
        check("hold_count", a_count, 3);
        step();
        a_valid = 1'b0;
        check("hash_coll", a_coll, 4'b1011);
        check("hash_busy", a_busy, 1);
        wait_idle_a();
        check("hash_count", a_count, 4);

        // reset on the second PRESS cycle of key 0
        a_code = 4'd0; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        check("k0_coll", a_coll, 4'b1101);
        step();
        check("k0_coll2", a_coll, 4'b1101);
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
        check("mid_rst_coll", a_coll, 4'hF);
        check("mid_rst_busy", a_busy, 0);
        check("mid_rst_ready", a_ready, 1);
        check("mid_rst_count", a_count, 0);
        step();
        check("post_rst_coll", a_coll, 4'hF);
        check("post_rst_busy", a_busy, 0);

        // reset wins over a simultaneous request
        a_rst = 1'b1; a_valid = 1'b1; a_code = 4'd5;
        step();
        a_rst = 1'b0; a_valid = 1'b0;
        check("rst_prio_busy", a_busy, 0);
        step();
        check("rst_prio_busy2", a_busy, 0);
        check("rst_prio_coll", a_coll, 4'hF);

        // 256 back-to-back presses, HOLD=1 GAP=1: one press per 3 cycles
        b_line = 4'b1101; b_code = 4'd5; b_valid = 1'b1;
        step();
        check("b_press_coll", b_coll, 4'b1101);
        step();
        for (int p = 1; p <= 256; p++) begin
            if (p == 1 || p == 2 || p == 128 || p == 255 || p == 256)
                check("wrap_count", b_count, p[7:0]);
            if (p < 256) begin
                step();
                step();
                step();
            end
        end
        b_valid = 1'b0;
        check("wrap_busy", b_busy, 1);

        // bounce window (or steady press without the macro), HOLD=12 BOUNCE=8
        c_line = 4'b1110; c_code = 4'd1; c_valid = 1'b1;
        step();
        c_valid = 1'b0;
        for (int k = 0; k < 12; k++) exp_q.push_back(bounce_exp[k]);
        exp_q.push_back(4'hF);
        for (int k = 0; k < 13; k++) begin
            exp_coll = exp_q.pop_front();
            check("bounce_coll", c_coll, exp_coll);
            step();
        end
        check("bounce_count", c_count, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
